// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adc_seq_pkg
// Brief   : Shared state encoding and result width for the ADC averaging
//           sequencer.
// Revision: 1.0
// ============================================================================
package adc_seq_pkg;

  localparam int RES_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TRIG = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module  : sync_edge_det
// Brief   : Two-flop synchroniser plus rising-edge pulse for asynchronous
//           handshake lines.
// Revision: 1.0
// ============================================================================
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise_pulse = sync_q[1] & ~sync_q[2];

endmodule
`default_nettype wire

// File: rtl/adc_avg_seq.sv
`default_nettype none
// ============================================================================
// Module  : adc_avg_seq
// Brief   : Triggers 2^LOG2_N SAR conversions, accumulates them and outputs
//           the raw sum and rounded average with a one-cycle valid strobe.
// Revision: 1.0
// ============================================================================
module adc_avg_seq
  import adc_seq_pkg::*;
#(
  parameter int LOG2_N      = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    adc_done,
  input  logic [RES_W-1:0]        result,
  output logic                    st_conv,
  output logic                    busy,
  output logic [RES_W+LOG2_N-1:0] sum_out,
  output logic [RES_W-1:0]        avg_out,
  output logic                    avg_valid,
  output logic                    timeout_err
);

  localparam int              SUM_W    = RES_W + LOG2_N;
  localparam int              CNT_W    = LOG2_N + 1;
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'((1 << LOG2_N) - 1);
  localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   smp_q, smp_d;
  logic [15:0]        tmo_q, tmo_d;
  logic               st_conv_q, st_conv_d;
  logic               busy_q, busy_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [RES_W-1:0]   avg_q, avg_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               done_rise;
  logic [RES_W-1:0]   avg_calc;

  sync_edge_det u_done_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (adc_done),
    .rise_pulse (done_rise)
  );

  // floor((acc + 2^(L-1)) / 2^L) == (acc >> L) + acc[L-1]; the max sum keeps
  // this within 10 bits, so the carry bit of the rounding add is always zero.
  if (LOG2_N == 0) begin : g_no_round
    assign avg_calc = acc_q;
  end else begin : g_round
    assign avg_calc = acc_q[SUM_W-1 -: RES_W]
                    + {{(RES_W-1){1'b0}}, acc_q[LOG2_N-1]};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    smp_d   = smp_q;
    tmo_d   = tmo_q;
    sum_d   = sum_q;
    avg_d   = avg_q;
    valid_d = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          smp_d   = '0;
          err_d   = 1'b0;
          state_d = ST_TRIG;
        end
      end
      ST_TRIG: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise) begin
          state_d = ST_ACC;
        end else if (tmo_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_ACC: begin
        acc_d   = acc_q + SUM_W'(result);
        smp_d   = smp_q + CNT_W'(1);
        state_d = (smp_q == LAST_SMP) ? ST_DONE : ST_TRIG;
      end
      ST_DONE: begin
        sum_d   = acc_q;
        avg_d   = avg_calc;
        valid_d = 1'b1;
        acc_d   = '0;
        smp_d   = '0;
        state_d = cont ? ST_TRIG : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up with it
    st_conv_d = (state_d == ST_TRIG);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      smp_q     <= '0;
      tmo_q     <= '0;
      st_conv_q <= 1'b0;
      busy_q    <= 1'b0;
      sum_q     <= '0;
      avg_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      smp_q     <= smp_d;
      tmo_q     <= tmo_d;
      st_conv_q <= st_conv_d;
      busy_q    <= busy_d;
      sum_q     <= sum_d;
      avg_q     <= avg_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign st_conv     = st_conv_q;
  assign busy        = busy_q;
  assign sum_out     = sum_q;
  assign avg_out     = avg_q;
  assign avg_valid   = valid_q;
  assign timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_avg_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_avg_seq
// Brief   : Directed self-checking bench for adc_avg_seq (LOG2_N=2, timeout 255).
// Revision: 1.0
// ============================================================================
module tb_adc_avg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cont;
  logic        model_done;
  logic        spur_done;
  logic [9:0]  result;
  wire         adc_done_w;
  logic        st_conv;
  logic        busy;
  logic [11:0] sum_out;
  logic [9:0]  avg_out;
  logic        avg_valid;
  logic        timeout_err;

  assign adc_done_w = model_done | spur_done;

  always #5 clk = ~clk;

  adc_avg_seq #(.LOG2_N(2), .TIMEOUT_CYC(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cont        (cont),
    .adc_done    (adc_done_w),
    .result      (result),
    .st_conv     (st_conv),
    .busy        (busy),
    .sum_out     (sum_out),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid),
    .timeout_err (timeout_err)
  );

  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_valid = 0;
  int conv_t[$];
  int codes[$];
  bit adc_en  = 1'b1;

  // ADC model: new code on st_conv, done rises 3 cycles later for 2 cycles
  initial begin
    model_done = 1'b0;
    result     = '0;
    forever begin
      @(posedge clk); #1;
      if (st_conv && adc_en) begin
        model_done = 1'b0;
        if (codes.size() > 0) result = 10'(codes.pop_front());
        repeat (3) @(posedge clk);
        #1 model_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 model_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (st_conv) conv_t.push_back(cyc);
    if (avg_valid) n_valid <= n_valid + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (avg_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int c[4];
    int sum;
    int avg;
  } vec_t;

  vec_t vt[4];
  int   c0, v0;
  bit   got;

  initial begin
    vt[0].c = '{512, 512, 512, 512};  vt[0].sum = 2048; vt[0].avg = 512;
    vt[1].c = '{1, 2, 2, 2};          vt[1].sum = 7;    vt[1].avg = 2;
    vt[2].c = '{0, 0, 0, 1023};       vt[2].sum = 1023; vt[2].avg = 256;
    vt[3].c = '{1023, 1023, 1023, 1023}; vt[3].sum = 4092; vt[3].avg = 1023;

    rst = 1'b1; start = 1'b0; cont = 1'b0; spur_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_st_conv", st_conv, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sum", sum_out, 0);
    chk("reset_avg", avg_out, 0);
    chk("reset_valid", avg_valid, 0);
    chk("reset_err", timeout_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single bursts from the vector table
    for (int i = 0; i < 4; i++) begin
      #1;
      c0 = conv_t.size(); v0 = n_valid;
      for (int k = 0; k < 4; k++) codes.push_back(vt[i].c[k]);
      pulse_start();
      chk("burst_trig_stconv", st_conv, 1);
      chk("burst_busy", busy, 1);
      wait_valid(200, got);
      chk("burst_valid_seen", got, 1);
      chk("burst_sum", sum_out, vt[i].sum);
      chk("burst_avg", avg_out, vt[i].avg);
      chk("burst_idle_busy", busy, 0);
      repeat (20) @(negedge clk); #1;
      chk("burst_conv_count", conv_t.size() - c0, 4);
      chk("burst_valid_count", n_valid - v0, 1);
    end

    // Timeout: ADC never answers
    adc_en = 1'b0; v0 = n_valid;
    pulse_start();
    chk("to_trig_stconv", st_conv, 1);
    @(negedge clk);
    repeat (254) @(negedge clk);
    chk("to_err_before", timeout_err, 0);
    chk("to_busy_before", busy, 1);
    @(negedge clk); #1;
    chk("to_err_set", timeout_err, 1);
    chk("to_busy_low", busy, 0);
    chk("to_avg_kept", avg_out, 1023);
    chk("to_sum_kept", sum_out, 4092);
    chk("to_no_valid", n_valid - v0, 0);

    // Spurious done edge in IDLE, then a burst with repeated start pulses
    adc_en = 1'b1;
    spur_done = 1'b1;
    repeat (3) @(negedge clk);
    spur_done = 1'b0;
    repeat (6) @(negedge clk); #1;
    c0 = conv_t.size(); v0 = n_valid;
    codes.push_back(10); codes.push_back(20); codes.push_back(30); codes.push_back(40);
    pulse_start();
    chk("err_cleared_on_start", timeout_err, 0);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_valid(200, got);
    chk("ign_valid_seen", got, 1);
    chk("ign_sum", sum_out, 100);
    chk("ign_avg", avg_out, 25);
    repeat (20) @(negedge clk); #1;
    chk("ign_conv_count", conv_t.size() - c0, 4);
    chk("ign_valid_count", n_valid - v0, 1);

    // Reset during the third conversion
    c0 = conv_t.size(); v0 = n_valid;
    codes.push_back(500); codes.push_back(500); codes.push_back(500);
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (conv_t.size() == c0 + 3) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_reached_third_trig", got, 1);
    rst = 1'b1; #1;
    chk("rst_st_conv", st_conv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_avg", avg_out, 0);
    chk("rst_valid", avg_valid, 0);
    chk("rst_err", timeout_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk); #1;
    chk("rst_no_valid", n_valid - v0, 0);
    for (int k = 0; k < 4; k++) codes.push_back(100);
    pulse_start();
    wait_valid(200, got);
    chk("rst_burst_valid_seen", got, 1);
    chk("rst_burst_sum", sum_out, 400);
    chk("rst_burst_avg", avg_out, 100);

    // Continuous mode with codes 0..7
    repeat (5) @(negedge clk); #1;
    c0 = conv_t.size(); v0 = n_valid;
    for (int k = 0; k < 8; k++) codes.push_back(k);
    cont = 1'b1;
    pulse_start();
    wait_valid(200, got);
    chk("cont_valid1_seen", got, 1);
    chk("cont_sum1", sum_out, 6);
    chk("cont_avg1", avg_out, 2);
    chk("cont_busy1", busy, 1);
    cont = 1'b0;
    wait_valid(200, got);
    chk("cont_valid2_seen", got, 1);
    chk("cont_sum2", sum_out, 22);
    chk("cont_avg2", avg_out, 6);
    chk("cont_idle_busy", busy, 0);
    repeat (30) @(negedge clk); #1;
    chk("cont_conv_count", conv_t.size() - c0, 8);
    chk("cont_valid_count", n_valid - v0, 2);
    if (conv_t.size() >= c0 + 5) begin
      chk("cont_gap_in_burst", conv_t[c0+1] - conv_t[c0], 7);
      chk("cont_gap_across_done", conv_t[c0+4] - conv_t[c0+3], 8);
    end else begin
      chk("cont_gap_samples_available", conv_t.size() - c0, 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
